// File: rtl/ahb_slave_sram.sv
// AHB responder backed by a WDT-wide word memory: programmable wait states,
// two-cycle ERROR response for illegal transfers, byte-lane masked writes.
//   state | meaning
//   IDLE  | no data phase in progress
//   WAIT  | inserting wait states, counter runs down to terminal count
//   DONE  | completion cycle, write commits at its end
//   ERR1  | first ERROR cycle, HREADY low
//   ERR2  | second ERROR cycle, HREADY high
module ahb_slave_sram #(
    parameter int WDT   = 32,
    parameter int DEPTH = 256
) (
    input  logic           i_hclk,
    input  logic           i_hreset,
    input  logic           i_hsel,
    input  logic           i_hready,
    input  logic [31:0]    i_haddr,
    input  logic [1:0]     i_htrans,
    input  logic           i_hwrite,
    input  logic [1:0]     i_hsize,
    input  logic [WDT-1:0] i_hwdata,
    input  logic [3:0]     i_wait_cfg,
    output logic           o_hready,
    output logic [1:0]     o_hresp,
    output logic [WDT-1:0] o_hrdata
);
    localparam int NB   = WDT / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [OFFW-1:0]     off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                write_q, write_d;
    logic                hready_q, err_q;
    logic [WDT-1:0]      rdata_q;

    logic [WDT-1:0]      mem [DEPTH];

    logic                can_acc, misalign, illegal, commit;
    logic [31:0]         acc_word;
    logic [IW-1:0]       acc_idx, rd_idx;
    logic [OFFW-1:0]     acc_off;
    logic [WDT-1:0]      wmask, merged, rd_word;
    int                  lane_lo, lane_hi;

    assign can_acc  = hready_q && i_hsel && i_hready && (i_htrans == 2'b10 || i_htrans == 2'b11);
    assign acc_word = i_haddr >> OFFW;
    assign acc_idx  = acc_word[IW-1:0];
    assign acc_off  = i_haddr[OFFW-1:0];

    always_comb begin
        misalign = 1'b0;
        case (i_hsize)
            2'd1:    misalign = i_haddr[0];
            2'd2:    misalign = |i_haddr[1:0];
            2'd3:    misalign = (WDT == 32) || (|i_haddr[2:0]);
            default: misalign = 1'b0;
        endcase
    end

    assign illegal = misalign || (acc_word >= 32'(DEPTH));

    always_comb begin
        wmask   = '0;
        lane_lo = int'(off_q);
        lane_hi = lane_lo + (1 << size_q);
        for (int b = 0; b < NB; b++) begin
            if (b >= lane_lo && b < lane_hi) wmask[b*8 +: 8] = 8'hFF;
        end
    end

    assign commit = (state_q == S_DONE) && write_q;
    assign merged = (mem[idx_q] & ~wmask) | (i_hwdata & wmask);
    assign rd_idx = (state_q == S_WAIT) ? idx_q : acc_idx;
    // A read landing on the word being committed this edge sees the merged value.
    assign rd_word = (commit && rd_idx == idx_q) ? merged : mem[rd_idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_DONE;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (can_acc) begin
                    idx_d   = acc_idx;
                    off_d   = acc_off;
                    size_d  = i_hsize;
                    write_d = i_hwrite;
                    cnt_d   = i_wait_cfg;
                    if (illegal)                 state_d = S_ERR1;
                    else if (i_wait_cfg != 4'd0) state_d = S_WAIT;
                    else                         state_d = S_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            off_q    <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            hready_q <= 1'b1;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            off_q    <= off_d;
            size_q   <= size_d;
            write_q  <= write_d;
            hready_q <= !(state_d == S_WAIT || state_d == S_ERR1);
            err_q    <= (state_d == S_ERR1 || state_d == S_ERR2);
            if (state_d == S_DONE) rdata_q <= rd_word;
        end
    end

    always_ff @(posedge i_hclk) begin
        if (commit) mem[idx_q] <= merged;
    end

    assign o_hready = hready_q;
    assign o_hresp  = {1'b0, err_q};
    assign o_hrdata = rdata_q;
endmodule

// File: tb/tb_ahb_slave_sram.sv
// Directed bench for ahb_slave_sram: single-slave bus, hand-computed expectations.
module tb_ahb_slave_sram;
    localparam int WDT   = 32;
    localparam int DEPTH = 256;

    logic           clk = 1'b0;
    logic           rst;
    logic           hsel;
    logic [31:0]    haddr;
    logic [1:0]     htrans;
    logic           hwrite;
    logic [1:0]     hsize;
    logic [WDT-1:0] hwdata;
    logic [3:0]     wait_cfg;
    logic           o_hready;
    logic [1:0]     o_hresp;
    logic [WDT-1:0] o_hrdata;
    wire            hready_bus;

    int total  = 0;
    int passed = 0;

    assign hready_bus = o_hready;

    always #5 clk = ~clk;

    ahb_slave_sram #(.WDT(WDT), .DEPTH(DEPTH)) dut (
        .i_hclk     (clk),
        .i_hreset   (rst),
        .i_hsel     (hsel),
        .i_hready   (hready_bus),
        .i_haddr    (haddr),
        .i_htrans   (htrans),
        .i_hwrite   (hwrite),
        .i_hsize    (hsize),
        .i_hwdata   (hwdata),
        .i_wait_cfg (wait_cfg),
        .o_hready   (o_hready),
        .o_hresp    (o_hresp),
        .o_hrdata   (o_hrdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [1:0] sz,
                              input logic [3:0] wc);
        hsel     = 1'b1;
        haddr    = a;
        htrans   = 2'b10;
        hwrite   = w;
        hsize    = sz;
        wait_cfg = wc;
    endtask

    task automatic finish_dphase();
        int n = 0;
        while (o_hready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        total++;
        if (n >= 40) $display("FAIL dphase_timeout: waited %0d cycles, required hready within 40", n);
        else passed++;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [WDT-1:0] d,
                            input logic [3:0] wc);
        addr_phase(a, 1'b1, sz, wc);
        step();
        idle_bus();
        hwdata = d;
        finish_dphase();
        step();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] wc, output logic [WDT-1:0] rd);
        addr_phase(a, 1'b0, 2'd2, wc);
        step();
        idle_bus();
        finish_dphase();
        rd = o_hrdata;
        step();
    endtask

    task automatic test_reset();
        #12;
        total++; if (o_hready !== 1'b1) $display("FAIL reset_hready: got %b want 1", o_hready); else passed++;
        total++; if (o_hresp !== 2'd0) $display("FAIL reset_hresp: got %0d want 0", o_hresp); else passed++;
        total++; if (o_hrdata !== 32'h0) $display("FAIL reset_hrdata: got %h want 0", o_hrdata); else passed++;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_forwarding();
        addr_phase(32'h10, 1'b1, 2'd2, 4'd0);
        step();
        hwdata = 32'hDEADBEEF;
        addr_phase(32'h10, 1'b0, 2'd2, 4'd0);
        step();
        idle_bus();
        total++; if (o_hrdata !== 32'hDEADBEEF) $display("FAIL fwd_rdata: got %h want deadbeef", o_hrdata); else passed++;
        total++; if (o_hresp !== 2'd0) $display("FAIL fwd_hresp: got %0d want 0", o_hresp); else passed++;
        total++; if (o_hready !== 1'b1) $display("FAIL fwd_hready: got %b want 1", o_hready); else passed++;
        step();
    endtask

    task automatic test_wait_states();
        do_write(32'h30, 2'd2, 32'hCAFEF00D, 4'd0);
        addr_phase(32'h30, 1'b0, 2'd2, 4'd3);
        step();
        idle_bus();
        for (int i = 0; i < 3; i++) begin
            total++; if (o_hready !== 1'b0) $display("FAIL wait_low[%0d]: got %b want 0", i, o_hready); else passed++;
            step();
        end
        total++; if (o_hready !== 1'b1) $display("FAIL wait_done_hready: got %b want 1", o_hready); else passed++;
        total++; if (o_hrdata !== 32'hCAFEF00D) $display("FAIL wait_rdata: got %h want cafef00d", o_hrdata); else passed++;
        step();
    endtask

    task automatic test_byte_write();
        logic [WDT-1:0] rd;
        do_write(32'h20, 2'd2, 32'h11223344, 4'd0);
        do_write(32'h21, 2'd0, 32'hAAAAAAAA, 4'd0);
        do_read(32'h20, 4'd0, rd);
        total++; if (rd !== 32'h1122AA44) $display("FAIL byte_write: got %h want 1122aa44", rd); else passed++;
        do_write(32'h22, 2'd1, 32'h55667777, 4'd2);
        do_read(32'h20, 4'd1, rd);
        total++; if (rd !== 32'h5566AA44) $display("FAIL half_write: got %h want 5566aa44", rd); else passed++;
    endtask

    task automatic test_misaligned();
        logic [WDT-1:0] rd;
        do_write(32'h00, 2'd2, 32'h01020304, 4'd0);
        do_read(32'h00, 4'd0, rd);
        addr_phase(32'h03, 1'b1, 2'd1, 4'd0);
        step();
        idle_bus();
        hwdata = 32'hFFFFFFFF;
        total++; if (o_hready !== 1'b0) $display("FAIL mis_err1_hready: got %b want 0", o_hready); else passed++;
        total++; if (o_hresp !== 2'd1) $display("FAIL mis_err1_hresp: got %0d want 1", o_hresp); else passed++;
        step();
        total++; if (o_hready !== 1'b1) $display("FAIL mis_err2_hready: got %b want 1", o_hready); else passed++;
        total++; if (o_hresp !== 2'd1) $display("FAIL mis_err2_hresp: got %0d want 1", o_hresp); else passed++;
        step();
        total++; if (o_hresp !== 2'd0) $display("FAIL mis_idle_hresp: got %0d want 0", o_hresp); else passed++;
        do_read(32'h00, 4'd0, rd);
        total++; if (rd !== 32'h01020304) $display("FAIL mis_mem_kept: got %h want 01020304", rd); else passed++;
    endtask

    task automatic test_out_of_range();
        addr_phase(32'(DEPTH * 4), 1'b0, 2'd2, 4'd0);
        step();
        idle_bus();
        total++; if (o_hready !== 1'b0 || o_hresp !== 2'd1)
            $display("FAIL oor_err1: got hready=%b hresp=%0d want 0/1", o_hready, o_hresp); else passed++;
        total++; if (o_hrdata !== 32'h01020304) $display("FAIL oor_rdata1: got %h want 01020304", o_hrdata); else passed++;
        step();
        total++; if (o_hready !== 1'b1 || o_hresp !== 2'd1)
            $display("FAIL oor_err2: got hready=%b hresp=%0d want 1/1", o_hready, o_hresp); else passed++;
        total++; if (o_hrdata !== 32'h01020304) $display("FAIL oor_rdata2: got %h want 01020304", o_hrdata); else passed++;
        step();
        addr_phase(32'h08, 1'b0, 2'd3, 4'd0);
        step();
        idle_bus();
        total++; if (o_hready !== 1'b0 || o_hresp !== 2'd1)
            $display("FAIL dword_err1: got hready=%b hresp=%0d want 0/1", o_hready, o_hresp); else passed++;
        step();
        step();
    endtask

    task automatic test_ignored();
        hsel   = 1'b1;
        haddr  = 32'h10;
        htrans = 2'b01;
        hwrite = 1'b0;
        hsize  = 2'd2;
        step();
        total++; if (o_hready !== 1'b1 || o_hresp !== 2'd0)
            $display("FAIL busy_ignored: got hready=%b hresp=%0d want 1/0", o_hready, o_hresp); else passed++;
        hsel   = 1'b0;
        htrans = 2'b10;
        wait_cfg = 4'd4;
        step();
        total++; if (o_hready !== 1'b1) $display("FAIL unsel_ignored: got %b want 1", o_hready); else passed++;
        idle_bus();
        step();
    endtask

    task automatic test_back_to_back();
        addr_phase(32'h400, 1'b0, 2'd2, 4'd0);
        step();
        addr_phase(32'h20, 1'b0, 2'd2, 4'd0);
        step();
        step();
        idle_bus();
        total++; if (o_hrdata !== 32'h5566AA44) $display("FAIL b2b_rdata: got %h want 5566aa44", o_hrdata); else passed++;
        total++; if (o_hready !== 1'b1 || o_hresp !== 2'd0)
            $display("FAIL b2b_done: got hready=%b hresp=%0d want 1/0", o_hready, o_hresp); else passed++;
        step();
    endtask

    task automatic test_reset_mid_wait();
        logic [WDT-1:0] rd;
        do_write(32'h40, 2'd2, 32'h55667788, 4'd0);
        addr_phase(32'h40, 1'b1, 2'd2, 4'd5);
        step();
        idle_bus();
        hwdata = 32'hFFFFFFFF;
        total++; if (o_hready !== 1'b0) $display("FAIL rst_wait_entry: got %b want 0", o_hready); else passed++;
        step();
        #2 rst = 1'b1;
        #1;
        total++; if (o_hready !== 1'b1 || o_hresp !== 2'd0)
            $display("FAIL rst_mid_wait: got hready=%b hresp=%0d want 1/0", o_hready, o_hresp); else passed++;
        total++; if (o_hrdata !== 32'h0) $display("FAIL rst_mid_rdata: got %h want 0", o_hrdata); else passed++;
        @(negedge clk);
        rst = 1'b0;
        step();
        do_read(32'h40, 4'd0, rd);
        total++; if (rd !== 32'h55667788) $display("FAIL rst_no_commit: got %h want 55667788", rd); else passed++;
    endtask

    initial begin
        rst      = 1'b1;
        hsel     = 1'b0;
        haddr    = '0;
        htrans   = 2'b00;
        hwrite   = 1'b0;
        hsize    = 2'd2;
        hwdata   = '0;
        wait_cfg = 4'd0;
        test_reset();
        test_forwarding();
        test_wait_states();
        test_byte_write();
        test_misaligned();
        test_out_of_range();
        test_ignored();
        test_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
